// File: rtl/acc_pkg.sv
// Shared accelerator-interface types: instruction kinds, FP memory opcodes and the
// per-instruction metadata carried from dispatch to response.
package acc_pkg;

    localparam int unsigned AccTransIdBits = 3;

    localparam logic [6:0] ACC_OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] ACC_OPC_STORE_FP = 7'b0100111;

    typedef enum logic [1:0] {
        ACC_COMPUTE,
        ACC_LOAD,
        ACC_STORE
    } acc_kind_e;

    typedef struct packed {
        logic [AccTransIdBits-1:0] trans_id;
        acc_kind_e                 kind;
    } acc_meta_t;

    function automatic acc_kind_e acc_classify(input logic [6:0] opcode);
        acc_kind_e kind;
        kind = ACC_COMPUTE;
        if (opcode == ACC_OPC_LOAD_FP) begin
            kind = ACC_LOAD;
        end else if (opcode == ACC_OPC_STORE_FP) begin
            kind = ACC_STORE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/acc_resp_register.sv
// Completion-to-response skid register: captures one back-end completion plus its tag and
// kind, holds it stable until the core takes it, and reloads in the handshake cycle.
module acc_resp_register
    import acc_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned TransIdBits = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_valid_i,
    output logic                   load_ready_o,
    input  logic [TransIdBits-1:0] trans_id_i,
    input  acc_kind_e              kind_i,
    input  logic [XLEN-1:0]        result_i,
    input  logic                   error_i,
    input  logic                   fflags_valid_i,
    input  logic [4:0]             fflags_i,
    input  logic                   resp_ready_i,
    output logic                   resp_valid_o,
    output logic [TransIdBits-1:0] resp_trans_id_o,
    output logic [XLEN-1:0]        resp_result_o,
    output logic                   resp_error_o,
    output logic                   resp_fflags_valid_o,
    output logic [4:0]             resp_fflags_o,
    output acc_kind_e              resp_kind_o
);

    typedef struct packed {
        logic [TransIdBits-1:0] trans_id;
        acc_kind_e              kind;
        logic [XLEN-1:0]        result;
        logic                   error;
        logic                   fflags_valid;
        logic [4:0]             fflags;
    } resp_t;

    resp_t resp_q, resp_d;
    logic  valid_q, valid_d;

    assign load_ready_o        = !valid_q || resp_ready_i;
    assign resp_valid_o        = valid_q;
    assign resp_trans_id_o     = resp_q.trans_id;
    assign resp_result_o       = resp_q.result;
    assign resp_error_o        = resp_q.error;
    assign resp_fflags_valid_o = resp_q.fflags_valid;
    assign resp_fflags_o       = resp_q.fflags;
    assign resp_kind_o         = resp_q.kind;

    always_comb begin
        valid_d = valid_q;
        resp_d  = resp_q;
        if (valid_q && resp_ready_i) begin
            valid_d = 1'b0;
        end
        if (load_valid_i && load_ready_o) begin
            valid_d             = 1'b1;
            resp_d.trans_id     = trans_id_i;
            resp_d.kind         = kind_i;
            resp_d.result       = result_i;
            resp_d.error        = error_i;
            resp_d.fflags_valid = fflags_valid_i;
            resp_d.fflags       = fflags_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            resp_q  <= '0;
        end else begin
            valid_q <= valid_d;
            resp_q  <= resp_d;
        end
    end

    a_resp_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_q && !resp_ready_i) |=> (valid_q && $stable(resp_q)));

endmodule

// File: rtl/fifo_v3.sv
// Common synchronous FIFO with optional fall-through; DEPTH is expected to be a power of 2.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [ADDR_DEPTH-1:0] read_ptr_q, read_ptr_d;
    logic [ADDR_DEPTH-1:0] write_ptr_q, write_ptr_d;
    logic [ADDR_DEPTH:0]   status_cnt_q, status_cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    assign usage_o = status_cnt_q[ADDR_DEPTH-1:0];
    assign full_o  = (status_cnt_q == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o = (status_cnt_q == '0) && !(FALL_THROUGH && push_i);

    always_comb begin
        read_ptr_d   = read_ptr_q;
        write_ptr_d  = write_ptr_q;
        status_cnt_d = status_cnt_q;
        data_o       = mem_q[read_ptr_q];
        if (push_i && !full_o) begin
            write_ptr_d  = (write_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0
                                                                   : write_ptr_q + ADDR_DEPTH'(1);
            status_cnt_d = status_cnt_q + (ADDR_DEPTH+1)'(1);
        end
        if (pop_i && !empty_o) begin
            read_ptr_d   = (read_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0
                                                                  : read_ptr_q + ADDR_DEPTH'(1);
            status_cnt_d = status_cnt_d - (ADDR_DEPTH+1)'(1);
        end
        if (FALL_THROUGH && (status_cnt_q == '0) && push_i) begin
            data_o = data_i;
        end
        if (flush_i) begin
            read_ptr_d   = '0;
            write_ptr_d  = '0;
            status_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_ptr_q   <= '0;
            write_ptr_q  <= '0;
            status_cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            read_ptr_q   <= read_ptr_d;
            write_ptr_q  <= write_ptr_d;
            status_cnt_q <= status_cnt_d;
            if (push_i && !full_o) begin
                mem_q[write_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/acc_req_responder.sv
// Accelerator-side front end: buffers core requests, issues them in order to the back-end,
// tags completions with trans_id and tracks outstanding accelerator stores.
module acc_req_responder
    import acc_pkg::*;
#(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned TransIdBits    = AccTransIdBits,
    parameter int unsigned ReqDepth       = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            req_insn_i,
    input  logic [XLEN-1:0]        req_rs1_i,
    input  logic [XLEN-1:0]        req_rs2_i,
    input  logic [2:0]             req_frm_i,
    input  logic [TransIdBits-1:0] req_trans_id_i,
    input  logic                   req_store_pending_i,
    input  logic                   req_acc_cons_en_i,
    input  logic                   resp_ready_i,
    output logic                   resp_valid_o,
    output logic [TransIdBits-1:0] resp_trans_id_o,
    output logic [XLEN-1:0]        resp_result_o,
    output logic                   resp_error_o,
    output logic                   resp_fflags_valid_o,
    output logic [4:0]             resp_fflags_o,
    output logic                   resp_store_pending_o,
    output logic                   resp_load_complete_o,
    output logic                   resp_store_complete_o,
    output logic                   exe_valid_o,
    input  logic                   exe_ready_i,
    output logic [31:0]            exe_insn_o,
    output logic [XLEN-1:0]        exe_rs1_o,
    output logic [XLEN-1:0]        exe_rs2_o,
    output logic [2:0]             exe_frm_o,
    input  logic                   exe_done_i,
    output logic                   exe_done_ready_o,
    input  logic [XLEN-1:0]        exe_result_i,
    input  logic                   exe_error_i,
    input  logic                   exe_fflags_valid_i,
    input  logic [4:0]             exe_fflags_i
);

    localparam int unsigned CntW   = $clog2(MaxOutstanding) + 1;
    localparam int unsigned ReqAw  = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
    localparam int unsigned MetaAw = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef struct packed {
        logic [31:0]            insn;
        logic [XLEN-1:0]        rs1;
        logic [XLEN-1:0]        rs2;
        logic [2:0]             frm;
        logic [TransIdBits-1:0] trans_id;
    } req_t;

    req_t              req_in, req_head;
    logic              req_full, req_empty, req_push;
    logic [ReqAw-1:0]  req_usage;
    acc_meta_t         meta_in, meta_head;
    logic              meta_full, meta_empty;
    logic [MetaAw-1:0] meta_usage;
    acc_kind_e         head_kind, resp_kind;
    logic              hold, exe_fire, done_fire, resp_fire, resp_load_ready;
    logic              store_inc, store_dec;
    logic [CntW-1:0]   store_cnt_q, store_cnt_d;
    logic              unused_usage;

    assign unused_usage = ^{req_usage, meta_usage};

    assign req_in = '{insn: req_insn_i, rs1: req_rs1_i, rs2: req_rs2_i, frm: req_frm_i,
                      trans_id: req_trans_id_i};
    assign req_ready_o = !req_full;
    assign req_push    = req_valid_i && req_ready_o;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   ($bits(req_t)),
        .DEPTH        (ReqDepth)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (!rst_i),
        .flush_i (1'b0),
        .full_o  (req_full),
        .empty_o (req_empty),
        .usage_o (req_usage),
        .data_i  (req_in),
        .push_i  (req_push),
        .data_o  (req_head),
        .pop_i   (exe_fire)
    );

    // Memory-consistent mode: a load must not overtake scalar stores still in flight in the core.
    assign head_kind   = acc_classify(req_head.insn[6:0]);
    assign hold        = (head_kind == ACC_LOAD) && req_acc_cons_en_i && req_store_pending_i;
    assign exe_valid_o = !req_empty && !meta_full && !hold;
    assign exe_fire    = exe_valid_o && exe_ready_i;
    assign exe_insn_o  = req_head.insn;
    assign exe_rs1_o   = req_head.rs1;
    assign exe_rs2_o   = req_head.rs2;
    assign exe_frm_o   = req_head.frm;

    assign meta_in = '{trans_id: AccTransIdBits'(req_head.trans_id), kind: head_kind};

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   ($bits(acc_meta_t)),
        .DEPTH        (MaxOutstanding)
    ) u_meta_fifo (
        .clk_i   (clk_i),
        .rst_ni  (!rst_i),
        .flush_i (1'b0),
        .full_o  (meta_full),
        .empty_o (meta_empty),
        .usage_o (meta_usage),
        .data_i  (meta_in),
        .push_i  (exe_fire),
        .data_o  (meta_head),
        .pop_i   (done_fire)
    );

    assign exe_done_ready_o = !meta_empty && resp_load_ready;
    assign done_fire        = exe_done_i && exe_done_ready_o;

    acc_resp_register #(
        .XLEN        (XLEN),
        .TransIdBits (TransIdBits)
    ) u_resp_reg (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .load_valid_i        (exe_done_i && !meta_empty),
        .load_ready_o        (resp_load_ready),
        .trans_id_i          (TransIdBits'(meta_head.trans_id)),
        .kind_i              (meta_head.kind),
        .result_i            (exe_result_i),
        .error_i             (exe_error_i),
        .fflags_valid_i      (exe_fflags_valid_i),
        .fflags_i            (exe_fflags_i),
        .resp_ready_i        (resp_ready_i),
        .resp_valid_o        (resp_valid_o),
        .resp_trans_id_o     (resp_trans_id_o),
        .resp_result_o       (resp_result_o),
        .resp_error_o        (resp_error_o),
        .resp_fflags_valid_o (resp_fflags_valid_o),
        .resp_fflags_o       (resp_fflags_o),
        .resp_kind_o         (resp_kind)
    );

    assign resp_fire             = resp_valid_o && resp_ready_i;
    assign resp_load_complete_o  = resp_fire && (resp_kind == ACC_LOAD);
    assign resp_store_complete_o = resp_fire && (resp_kind == ACC_STORE);

    assign store_inc = exe_fire && (head_kind == ACC_STORE);
    assign store_dec = resp_fire && (resp_kind == ACC_STORE);

    always_comb begin
        store_cnt_d = store_cnt_q;
        if (store_inc && !store_dec) begin
            store_cnt_d = store_cnt_q + CntW'(1);
        end else if (store_dec && !store_inc) begin
            store_cnt_d = store_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            store_cnt_q <= '0;
        end else begin
            store_cnt_q <= store_cnt_d;
        end
    end

    assign resp_store_pending_o = (store_cnt_q != '0);

    a_done_needs_meta: assert property (@(posedge clk_i) disable iff (rst_i)
        exe_done_i |-> !meta_empty);
    a_cnt_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (store_inc && !store_dec) |-> (store_cnt_q != CntW'(MaxOutstanding)));
    a_cnt_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (store_dec && !store_inc) |-> (store_cnt_q != '0));

endmodule

// File: tb/tb_acc_req_responder.sv
// Directed bench for acc_req_responder: compute, store, held load, full back-end window,
// coinciding store dispatch/response and asynchronous reset mid-operation.
module tb_acc_req_responder;

    localparam int unsigned XLEN = 64;
    localparam int unsigned TidW = 3;

    localparam logic [31:0] INSN_COMPUTE = 32'h0000_0053;
    localparam logic [31:0] INSN_LOAD    = 32'h0000_2007;
    localparam logic [31:0] INSN_STORE   = 32'h0000_2027;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            req_valid_i, req_ready_o;
    logic [31:0]     req_insn_i;
    logic [XLEN-1:0] req_rs1_i, req_rs2_i;
    logic [2:0]      req_frm_i;
    logic [TidW-1:0] req_trans_id_i;
    logic            req_store_pending_i, req_acc_cons_en_i;
    logic            resp_ready_i, resp_valid_o;
    logic [TidW-1:0] resp_trans_id_o;
    logic [XLEN-1:0] resp_result_o;
    logic            resp_error_o, resp_fflags_valid_o;
    logic [4:0]      resp_fflags_o;
    logic            resp_store_pending_o, resp_load_complete_o, resp_store_complete_o;
    logic            exe_valid_o, exe_ready_i;
    logic [31:0]     exe_insn_o;
    logic [XLEN-1:0] exe_rs1_o, exe_rs2_o;
    logic [2:0]      exe_frm_o;
    logic            exe_done_i, exe_done_ready_o;
    logic [XLEN-1:0] exe_result_i;
    logic            exe_error_i, exe_fflags_valid_i;
    logic [4:0]      exe_fflags_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = !clk_i;

    acc_req_responder #(
        .XLEN           (XLEN),
        .TransIdBits    (TidW),
        .ReqDepth       (2),
        .MaxOutstanding (4)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .req_valid_i           (req_valid_i),
        .req_ready_o           (req_ready_o),
        .req_insn_i            (req_insn_i),
        .req_rs1_i             (req_rs1_i),
        .req_rs2_i             (req_rs2_i),
        .req_frm_i             (req_frm_i),
        .req_trans_id_i        (req_trans_id_i),
        .req_store_pending_i   (req_store_pending_i),
        .req_acc_cons_en_i     (req_acc_cons_en_i),
        .resp_ready_i          (resp_ready_i),
        .resp_valid_o          (resp_valid_o),
        .resp_trans_id_o       (resp_trans_id_o),
        .resp_result_o         (resp_result_o),
        .resp_error_o          (resp_error_o),
        .resp_fflags_valid_o   (resp_fflags_valid_o),
        .resp_fflags_o         (resp_fflags_o),
        .resp_store_pending_o  (resp_store_pending_o),
        .resp_load_complete_o  (resp_load_complete_o),
        .resp_store_complete_o (resp_store_complete_o),
        .exe_valid_o           (exe_valid_o),
        .exe_ready_i           (exe_ready_i),
        .exe_insn_o            (exe_insn_o),
        .exe_rs1_o             (exe_rs1_o),
        .exe_rs2_o             (exe_rs2_o),
        .exe_frm_o             (exe_frm_o),
        .exe_done_i            (exe_done_i),
        .exe_done_ready_o      (exe_done_ready_o),
        .exe_result_i          (exe_result_i),
        .exe_error_i           (exe_error_i),
        .exe_fflags_valid_i    (exe_fflags_valid_i),
        .exe_fflags_i          (exe_fflags_i)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic [31:0] insn, input logic [63:0] rs1,
                           input logic [TidW-1:0] tid);
        req_valid_i    = 1'b1;
        req_insn_i     = insn;
        req_rs1_i      = rs1;
        req_rs2_i      = rs1 + 64'd1;
        req_frm_i      = 3'd1;
        req_trans_id_i = tid;
    endtask

    initial begin
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_insn_i = '0; req_rs1_i = '0; req_rs2_i = '0; req_frm_i = '0;
        req_trans_id_i = '0; req_store_pending_i = 1'b0; req_acc_cons_en_i = 1'b0;
        resp_ready_i = 1'b0; exe_ready_i = 1'b1; exe_done_i = 1'b0; exe_result_i = '0;
        exe_error_i = 1'b0; exe_fflags_valid_i = 1'b0; exe_fflags_i = '0;

        repeat (2) @(posedge clk_i);
        #3;
        check_eq("rst_req_ready", req_ready_o, 1);
        check_eq("rst_resp_valid", resp_valid_o, 0);
        check_eq("rst_exe_valid", exe_valid_o, 0);
        check_eq("rst_store_pend", resp_store_pending_o, 0);
        check_eq("rst_done_ready", exe_done_ready_o, 0);
        tick();
        rst_i = 1'b0;
        tick();

        // Compute: 3 and 4, tag 5, back-end answers 7 two cycles after dispatch.
        set_req(INSN_COMPUTE, 64'd3, 3'd5);
        req_rs2_i = 64'd4;
        #2 check_eq("c_req_ready", req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        #2;
        check_eq("c_exe_valid", exe_valid_o, 1);
        check_eq("c_exe_rs1", exe_rs1_o, 3);
        check_eq("c_exe_rs2", exe_rs2_o, 4);
        check_eq("c_exe_insn", exe_insn_o, 64'h53);
        check_eq("c_exe_frm", exe_frm_o, 1);
        tick();
        #2 check_eq("c_exe_valid_after", exe_valid_o, 0);
        tick();
        exe_done_i = 1'b1; exe_result_i = 64'd7;
        #2 check_eq("c_done_ready", exe_done_ready_o, 1);
        tick();
        exe_done_i = 1'b0; resp_ready_i = 1'b1;
        #2;
        check_eq("c_resp_valid", resp_valid_o, 1);
        check_eq("c_resp_tid", resp_trans_id_o, 5);
        check_eq("c_resp_result", resp_result_o, 7);
        check_eq("c_load_pulse", resp_load_complete_o, 0);
        check_eq("c_store_pulse", resp_store_complete_o, 0);
        tick();
        resp_ready_i = 1'b0;
        #2 check_eq("c_resp_done", resp_valid_o, 0);

        // Store, tag 2: pending from the cycle after dispatch until the response handshake.
        tick();
        set_req(INSN_STORE, 64'h1000, 3'd2);
        tick();
        req_valid_i = 1'b0;
        #2;
        check_eq("s_exe_valid", exe_valid_o, 1);
        check_eq("s_pend_before", resp_store_pending_o, 0);
        tick();
        #2 check_eq("s_pend_after_disp", resp_store_pending_o, 1);
        exe_done_i = 1'b1; exe_result_i = '0;
        tick();
        exe_done_i = 1'b0; resp_ready_i = 1'b1;
        #2;
        check_eq("s_resp_tid", resp_trans_id_o, 2);
        check_eq("s_store_pulse", resp_store_complete_o, 1);
        check_eq("s_load_pulse", resp_load_complete_o, 0);
        check_eq("s_pend_at_hs", resp_store_pending_o, 1);
        tick();
        resp_ready_i = 1'b0;
        #2;
        check_eq("s_store_pulse_off", resp_store_complete_o, 0);
        check_eq("s_pend_cleared", resp_store_pending_o, 0);

        // Load held back for 5 cycles by core-side pending stores in consistent mode.
        tick();
        req_acc_cons_en_i = 1'b1; req_store_pending_i = 1'b1;
        set_req(INSN_LOAD, 64'h2000, 3'd1);
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2 check_eq($sformatf("l_hold%0d", i), exe_valid_o, 0);
            tick();
        end
        req_store_pending_i = 1'b0;
        #2 check_eq("l_release", exe_valid_o, 1);
        tick();
        exe_done_i = 1'b1; exe_result_i = 64'h55;
        tick();
        exe_done_i = 1'b0; resp_ready_i = 1'b1;
        #2;
        check_eq("l_resp_tid", resp_trans_id_o, 1);
        check_eq("l_resp_result", resp_result_o, 64'h55);
        check_eq("l_load_pulse", resp_load_complete_o, 1);
        tick();
        resp_ready_i = 1'b0; req_acc_cons_en_i = 1'b0;
        #2 check_eq("l_load_pulse_off", resp_load_complete_o, 0);

        // Store B dispatched in the same cycle store A's response is taken.
        tick();
        set_req(INSN_STORE, 64'h3000, 3'd3);
        tick();
        req_valid_i = 1'b0;
        tick();
        #2 check_eq("x_pend_a", resp_store_pending_o, 1);
        exe_done_i = 1'b1; exe_result_i = '0;
        set_req(INSN_STORE, 64'h4000, 3'd4);
        tick();
        exe_done_i = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b1;
        #2;
        check_eq("x_resp_tid_a", resp_trans_id_o, 3);
        check_eq("x_store_pulse", resp_store_complete_o, 1);
        check_eq("x_exe_valid_b", exe_valid_o, 1);
        tick();
        resp_ready_i = 1'b0;
        #2;
        check_eq("x_pend_kept", resp_store_pending_o, 1);
        check_eq("x_resp_idle", resp_valid_o, 0);
        exe_done_i = 1'b1;
        tick();
        exe_done_i = 1'b0; resp_ready_i = 1'b1;
        #2 check_eq("x_resp_tid_b", resp_trans_id_o, 4);
        tick();
        resp_ready_i = 1'b0;
        #2 check_eq("x_pend_clear", resp_store_pending_o, 0);

        // Four computes fill the back-end window; a fifth waits.
        tick();
        for (int i = 0; i < 5; i++) begin
            set_req(INSN_COMPUTE, 64'(i), 3'(i));
            tick();
        end
        req_valid_i = 1'b0;
        #2;
        check_eq("w_fifth_blocked", exe_valid_o, 0);
        check_eq("w_done_ready", exe_done_ready_o, 1);
        tick();
        #2 check_eq("w_fifth_still", exe_valid_o, 0);
        exe_ready_i = 1'b0;
        exe_done_i = 1'b1; exe_result_i = 64'd100;
        tick();
        exe_result_i = 64'd101;
        #2;
        check_eq("w_stall_done_ready", exe_done_ready_o, 0);
        check_eq("w_resp0_tid", resp_trans_id_o, 0);
        check_eq("w_resp0_result", resp_result_o, 100);
        tick();
        #2;
        check_eq("w_hold_tid", resp_trans_id_o, 0);
        check_eq("w_hold_result", resp_result_o, 100);
        check_eq("w_hold_done_ready", exe_done_ready_o, 0);
        tick();
        resp_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exe_done_i = 1'b1; exe_result_i = 64'(101 + k);
            #2;
            check_eq($sformatf("w_tid%0d", k), resp_trans_id_o, 64'(k));
            check_eq($sformatf("w_res%0d", k), resp_result_o, 64'(100 + k));
            check_eq($sformatf("w_dr%0d", k), exe_done_ready_o, 1);
            tick();
        end
        exe_done_i = 1'b0; resp_ready_i = 1'b0;
        #2;
        check_eq("w_resp3_valid", resp_valid_o, 1);
        check_eq("w_resp3_tid", resp_trans_id_o, 3);
        check_eq("w_resp3_result", resp_result_o, 103);
        check_eq("w_meta_empty", exe_done_ready_o, 0);
        check_eq("w_fifth_ready", exe_valid_o, 1);
        set_req(INSN_COMPUTE, 64'd5, 3'd5);
        tick();
        req_valid_i = 1'b0;
        #2 check_eq("w_req_full", req_ready_o, 0);

        // Asynchronous reset with two requests queued and a response pending.
        rst_i = 1'b1;
        #1;
        check_eq("r_req_ready", req_ready_o, 1);
        check_eq("r_resp_valid", resp_valid_o, 0);
        check_eq("r_resp_tid", resp_trans_id_o, 0);
        check_eq("r_resp_result", resp_result_o, 0);
        check_eq("r_exe_valid", exe_valid_o, 0);
        check_eq("r_exe_insn", exe_insn_o, 0);
        check_eq("r_exe_rs1", exe_rs1_o, 0);
        check_eq("r_store_pend", resp_store_pending_o, 0);
        check_eq("r_done_ready", exe_done_ready_o, 0);
        tick();
        rst_i = 1'b0;
        exe_ready_i = 1'b1;
        tick();
        set_req(INSN_COMPUTE, 64'd9, 3'd6);
        tick();
        req_valid_i = 1'b0;
        #2;
        check_eq("p_exe_valid", exe_valid_o, 1);
        check_eq("p_exe_rs1", exe_rs1_o, 9);
        tick();
        exe_done_i = 1'b1; exe_result_i = 64'd42;
        tick();
        exe_done_i = 1'b0; resp_ready_i = 1'b1;
        #2;
        check_eq("p_resp_valid", resp_valid_o, 1);
        check_eq("p_resp_tid", resp_trans_id_o, 6);
        check_eq("p_resp_result", resp_result_o, 42);
        tick();
        resp_ready_i = 1'b0;
        #2;
        check_eq("p_resp_idle", resp_valid_o, 0);
        check_eq("p_req_ready", req_ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
